// File: rtl/mos_switch_eval.sv
// mos_switch_eval: registered, strength-free evaluator for nmos/pmos switch
// primitives and a six-switch CMOS AND cell (NAND stage + inverter), using a
// 2-bit 4-state code: 00 = 0, 01 = 1, 10 = Z, 11 = X.
module mos_switch_eval (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] sw_data,
  input  logic [1:0] sw_ctrl,
  input  logic [1:0] in_a,
  input  logic [1:0] in_b,
  output logic       out_valid,
  output logic [1:0] nmos_y,
  output logic [1:0] pmos_y,
  output logic [1:0] nand_y,
  output logic [1:0] and_y
);

  localparam int unsigned VW = 2;

  localparam logic [VW-1:0] V0 = 2'b00;
  localparam logic [VW-1:0] V1 = 2'b01;
  localparam logic [VW-1:0] VZ = 2'b10;
  localparam logic [VW-1:0] VX = 2'b11;

  // nmos switch: conducts on gate 1, floats on gate 0, unknown gate gives X
  // unless there is nothing to pass through.
  function automatic logic [VW-1:0] nmos_f(input logic [VW-1:0] d,
                                           input logic [VW-1:0] g);
    logic [VW-1:0] r;
    r = VX;
    case (g)
      V1:      r = d;
      V0:      r = VZ;
      default: r = (d == VZ) ? VZ : VX;
    endcase
    return r;
  endfunction

  // pmos switch: nmos with the gate sense inverted.
  function automatic logic [VW-1:0] pmos_f(input logic [VW-1:0] d,
                                           input logic [VW-1:0] g);
    logic [VW-1:0] r;
    r = VX;
    case (g)
      V0:      r = d;
      V1:      r = VZ;
      default: r = (d == VZ) ? VZ : VX;
    endcase
    return r;
  endfunction

  // Two-driver net resolution; Z is the identity and X/conflict absorb, so
  // chaining it resolves any number of drivers.
  function automatic logic [VW-1:0] res_f(input logic [VW-1:0] p,
                                          input logic [VW-1:0] q);
    logic [VW-1:0] r;
    if (p == VZ)                 r = q;
    else if (q == VZ)            r = p;
    else if (p == q && p != VX)  r = p;
    else                         r = VX;
    return r;
  endfunction

  logic [VW-1:0] w1_c;
  logic [VW-1:0] w2_c;
  logic [VW-1:0] y_c;
  logic [VW-1:0] n_c;
  logic [VW-1:0] p_c;

  // Combinational evaluation of the standalone switches and the AND cell.
  always_comb begin
    n_c  = nmos_f(sw_data, sw_ctrl);
    p_c  = pmos_f(sw_data, sw_ctrl);
    w1_c = nmos_f(V0, in_b);
    w2_c = res_f(res_f(pmos_f(V1, in_a), pmos_f(V1, in_b)), nmos_f(w1_c, in_a));
    y_c  = res_f(pmos_f(V1, w2_c), nmos_f(V0, w2_c));
  end

  // Output registers: load on valid, hold otherwise; valid flag follows input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      nmos_y    <= V0;
      pmos_y    <= V0;
      nand_y    <= V0;
      and_y     <= V0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        nmos_y <= n_c;
        pmos_y <= p_c;
        nand_y <= w2_c;
        and_y  <= y_c;
      end
    end
  end

endmodule

// File: tb/tb_mos_switch_eval.sv
// Directed, table-driven bench for mos_switch_eval.
module tb_mos_switch_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] sw_data, sw_ctrl, in_a, in_b;
  logic       out_valid;
  logic [1:0] nmos_y, pmos_y, nand_y, and_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mos_switch_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .sw_data(sw_data), .sw_ctrl(sw_ctrl), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .nmos_y(nmos_y), .pmos_y(pmos_y),
    .nand_y(nand_y), .and_y(and_y)
  );

  typedef struct packed {
    logic       v;
    logic [1:0] d, g, a, b;
    logic       ev;
    logic [1:0] en, ep, enand, eand;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] d, input logic [1:0] g,
                     input logic [1:0] a, input logic [1:0] b, input logic ev,
                     input logic [1:0] en, input logic [1:0] ep,
                     input logic [1:0] enand, input logic [1:0] eand);
    vec_t t;
    t = '{v, d, g, a, b, ev, en, ep, enand, eand};
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [1:0] en,
                         input logic [1:0] ep, input logic [1:0] enand,
                         input logic [1:0] eand);
    chk({tag, ".out_valid"}, {1'b0, out_valid}, {1'b0, ev});
    chk({tag, ".nmos_y"}, nmos_y, en);
    chk({tag, ".pmos_y"}, pmos_y, ep);
    chk({tag, ".nand_y"}, nand_y, enand);
    chk({tag, ".and_y"}, and_y, eand);
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [1:0] g,
                       input logic [1:0] a, input logic [1:0] b);
    in_valid = v; sw_data = d; sw_ctrl = g; in_a = a; in_b = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ra, rb;

    // switch sweep: cell held at a=0,b=0 (nand 01, and 00)
    //   v   d      g      a      b     ev  nmos   pmos   nand   and
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b01, 2'b00);
    add(1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b10, 2'b01, 2'b00);
    add(1, 2'b00, 2'b10, 2'b00, 2'b00, 1, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b01, 2'b01, 2'b00);
    add(1, 2'b01, 2'b01, 2'b00, 2'b00, 1, 2'b01, 2'b10, 2'b01, 2'b00);
    add(1, 2'b01, 2'b10, 2'b00, 2'b00, 1, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 2'b01, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 2'b10, 2'b01, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 2'b10, 2'b10, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 2'b10, 2'b11, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b11, 2'b01, 2'b00);
    add(1, 2'b11, 2'b01, 2'b00, 2'b00, 1, 2'b11, 2'b10, 2'b01, 2'b00);
    add(1, 2'b11, 2'b10, 2'b00, 2'b00, 1, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b11, 2'b01, 2'b00);
    // cell: switches at d=0,g=0 (nmos Z, pmos 0)
    add(1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 2'b10, 2'b00, 2'b01, 2'b00);
    add(1, 2'b00, 2'b00, 2'b01, 2'b00, 1, 2'b10, 2'b00, 2'b01, 2'b00);
    add(1, 2'b00, 2'b00, 2'b01, 2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b01);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b01, 2'b00);
    add(1, 2'b00, 2'b00, 2'b11, 2'b00, 1, 2'b10, 2'b00, 2'b11, 2'b11);
    add(1, 2'b00, 2'b00, 2'b10, 2'b01, 1, 2'b10, 2'b00, 2'b11, 2'b11);
    add(1, 2'b00, 2'b00, 2'b01, 2'b11, 1, 2'b10, 2'b00, 2'b11, 2'b11);
    // valid gating: load, then invalid with changed inputs holds
    add(1, 2'b01, 2'b01, 2'b01, 2'b01, 1, 2'b01, 2'b10, 2'b00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b01);

    // reset held 2 cycles with valid traffic
    rst = 1'b1;
    drive(1, 2'b01, 2'b01, 2'b01, 2'b01);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("reset%0d", i), 0, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    // release with no valid: nothing appears
    rst = 1'b0;
    drive(0, 2'b01, 2'b01, 2'b01, 2'b01);
    tick();
    chk_all("post_reset_idle", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    // first valid after reset appears one cycle later
    drive(1, 2'b01, 2'b01, 2'b01, 2'b01);
    tick();
    chk_all("first_valid", 1, 2'b01, 2'b10, 2'b00, 2'b01);

    // table
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].g, tbl[i].a, tbl[i].b);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].en, tbl[i].ep,
              tbl[i].enand, tbl[i].eand);
    end

    // reset mid-stream overrides in_valid
    rst = 1'b1;
    drive(1, 2'b01, 2'b01, 2'b01, 2'b01);
    tick();
    chk_all("mid_reset", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    // random known cell inputs, back to back
    for (int i = 0; i < 10; i++) begin
      ra = {1'b0, 1'($urandom_range(0, 1))};
      rb = {1'b0, 1'($urandom_range(0, 1))};
      drive(1, 2'b00, 2'b01, ra, rb);
      tick();
      chk($sformatf("rand%0d.out_valid", i), {1'b0, out_valid}, 2'b01);
      chk($sformatf("rand%0d.and_y", i), and_y, {1'b0, ra[0] & rb[0]});
      chk($sformatf("rand%0d.nand_y", i), nand_y, {1'b0, ~(ra[0] & rb[0])});
    end

    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    chk("final.out_valid", {1'b0, out_valid}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
